// File: rtl/ysyx_25040111_bus_arbiter.sv
// Two-master (I-cache refill, LSU) to one-slave memory port arbiter with per-transaction grant lock.
// Latency: grant one cycle after request; m_* request fields and ready/data/err returns are combinational while granted.
// Backpressure: the slave paces beats via m_ready; optional round-robin tie-break when ARB_RR_EN is defined.
module ysyx_25040111_bus_arbiter #(
   parameter int LEN_W   = 8,
   parameter bit D_FIRST = 1'b1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             i_valid,
   input  logic [31:0]      i_addr,
   input  logic [LEN_W-1:0] i_len,
   input  logic             i_burst,
   output logic             i_ready,
   output logic [31:0]      i_rdata,
   output logic             i_err,
   input  logic             d_valid,
   input  logic [31:0]      d_addr,
   input  logic             d_wen,
   input  logic [31:0]      d_wdata,
   input  logic [3:0]       d_wstrb,
   output logic             d_ready,
   output logic [31:0]      d_rdata,
   output logic             d_err,
   output logic             m_valid,
   output logic [31:0]      m_addr,
   output logic [LEN_W-1:0] m_len,
   output logic             m_burst,
   output logic             m_wen,
   output logic [31:0]      m_wdata,
   output logic [3:0]       m_wstrb,
   input  logic             m_ready,
   input  logic [31:0]      m_rdata,
   input  logic             m_err,
   output logic [1:0]       grant
);

   // State encoding doubles as the grant vector.
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      GNT_I = 2'b01,
      GNT_D = 2'b10
   } state_t;

   state_t           state, state_nxt;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W:0]   cnt_q;
   logic             pick_d;
   logic             last_beat;
   logic             xfer_end;

   assign last_beat = m_ready && (cnt_q == {1'b0, len_q});
   assign xfer_end  = (state != IDLE) && (m_err || last_beat);

`ifdef ARB_RR_EN
   // last_d = 1 when the LSU owned the most recently finished transaction.
   logic last_d;
   logic unused_d_first;
   assign unused_d_first = D_FIRST;

   // On a tie the master that did not go last wins.
   always_comb begin
      pick_d = d_valid && (!i_valid || !last_d);
   end

   // Remember who owned the bus when a transaction completes or aborts.
   always_ff @(posedge clock) begin
      if (reset) begin
         last_d <= 1'b1;
      end else if (xfer_end) begin
         last_d <= (state == GNT_D);
      end
   end
`else
   // Fixed priority on a tie.
   always_comb begin
      pick_d = d_valid && (!i_valid || D_FIRST);
   end
`endif

   // Next-state: lock the grant until the last beat or an error.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (pick_d)       state_nxt = GNT_D;
            else if (i_valid) state_nxt = GNT_I;
         end
         GNT_I, GNT_D: begin
            if (m_err || last_beat) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, latched length and beat counter.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         len_q <= '0;
         cnt_q <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE) begin
            cnt_q <= '0;
            if (state_nxt == GNT_I)      len_q <= i_len;
            else if (state_nxt == GNT_D) len_q <= '0;
         end else if (xfer_end) begin
            cnt_q <= '0;
         end else if (m_ready) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   // Downstream mux and return steering; everything is zero while idle.
   always_comb begin
      m_valid = 1'b0;
      m_addr  = '0;
      m_len   = '0;
      m_burst = 1'b0;
      m_wen   = 1'b0;
      m_wdata = '0;
      m_wstrb = '0;
      i_ready = 1'b0;
      i_rdata = '0;
      i_err   = 1'b0;
      d_ready = 1'b0;
      d_rdata = '0;
      d_err   = 1'b0;
      grant   = state;
      case (state)
         GNT_I: begin
            m_valid = i_valid;
            m_addr  = i_addr;
            m_len   = len_q;
            m_burst = i_burst;
            i_ready = m_ready && !m_err;
            i_rdata = m_rdata;
            i_err   = m_err;
         end
         GNT_D: begin
            m_valid = d_valid;
            m_addr  = d_addr;
            m_wen   = d_wen;
            m_wdata = d_wdata;
            m_wstrb = d_wstrb;
            d_ready = m_ready && !m_err;
            d_rdata = m_rdata;
            d_err   = m_err;
         end
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: tb/tb_ysyx_25040111_bus_arbiter.sv
// Bench for the two-master bus arbiter: transaction table plus tie, error and reset sequences.
// Latency: grant checked one cycle after request; returns checked in the same cycle as m_ready.
// Backpressure: the bench plays the slave and paces every beat with m_ready.
module tb_ysyx_25040111_bus_arbiter;
   localparam int LEN_W = 8;

   logic             clock = 1'b0;
   logic             reset;
   logic             i_valid, i_burst, i_ready, i_err;
   logic [31:0]      i_addr, i_rdata;
   logic [LEN_W-1:0] i_len;
   logic             d_valid, d_wen, d_ready, d_err;
   logic [31:0]      d_addr, d_wdata, d_rdata;
   logic [3:0]       d_wstrb;
   logic             m_valid, m_burst, m_wen, m_ready, m_err;
   logic [31:0]      m_addr, m_wdata, m_rdata;
   logic [LEN_W-1:0] m_len;
   logic [3:0]       m_wstrb;
   logic [1:0]       grant;

   ysyx_25040111_bus_arbiter #(.LEN_W(LEN_W), .D_FIRST(1'b1)) dut (
      .clock(clock), .reset(reset),
      .i_valid(i_valid), .i_addr(i_addr), .i_len(i_len), .i_burst(i_burst),
      .i_ready(i_ready), .i_rdata(i_rdata), .i_err(i_err),
      .d_valid(d_valid), .d_addr(d_addr), .d_wen(d_wen), .d_wdata(d_wdata),
      .d_wstrb(d_wstrb), .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err),
      .m_valid(m_valid), .m_addr(m_addr), .m_len(m_len), .m_burst(m_burst),
      .m_wen(m_wen), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
      .m_ready(m_ready), .m_rdata(m_rdata), .m_err(m_err), .grant(grant)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        is_d;
      logic [31:0] addr;
      logic [7:0]  len;
      logic        burst;
      logic        wen;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] rbase;
      logic [1:0]  exp_grant;
      logic [7:0]  exp_len;
      logic        exp_burst;
      logic        exp_wen;
      logic [31:0] exp_wdata;
      logic [3:0]  exp_wstrb;
   } vec_t;

   typedef struct {
      logic        to_d;
      logic [31:0] data;
   } sb_t;

   vec_t vecs[5];
   sb_t  sbq[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      i_valid = 1'b0; i_addr = '0; i_len = '0; i_burst = 1'b0;
      d_valid = 1'b0; d_addr = '0; d_wen = 1'b0; d_wdata = '0; d_wstrb = '0;
      m_ready = 1'b0; m_rdata = '0; m_err = 1'b0;
      step;
      step;
      reset = 1'b0;
   endtask

   // One slave beat: expectation queued when m_ready is driven, popped when a ready appears.
   task automatic beat(input logic [31:0] data, input logic to_d);
      sb_t e, got;
      e.to_d = to_d;
      e.data = data;
      sbq.push_back(e);
      m_ready = 1'b1;
      m_rdata = data;
      #1;
      chk("dual_ready", {31'b0, i_ready & d_ready}, 32'd0);
      if ((i_ready || d_ready) && sbq.size() > 0) begin
         got = sbq.pop_front();
         chk("ready_owner", {31'b0, d_ready}, {31'b0, got.to_d});
         chk("ready_rdata", d_ready ? d_rdata : i_rdata, got.data);
      end else begin
         chk("ready_seen", 32'd0, 32'd1);
      end
      step;
      m_ready = 1'b0;
      m_rdata = '0;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      if (v.is_d) begin
         d_valid = 1'b1; d_addr = v.addr; d_wen = v.wen; d_wdata = v.wdata; d_wstrb = v.wstrb;
      end else begin
         i_valid = 1'b1; i_addr = v.addr; i_len = v.len; i_burst = v.burst;
      end
      step;
      chk($sformatf("v%0d_grant", idx), {30'b0, grant}, {30'b0, v.exp_grant});
      chk($sformatf("v%0d_m_valid", idx), {31'b0, m_valid}, 32'd1);
      chk($sformatf("v%0d_m_addr", idx), m_addr, v.addr);
      chk($sformatf("v%0d_m_len", idx), 32'(m_len), 32'(v.exp_len));
      chk($sformatf("v%0d_m_burst", idx), {31'b0, m_burst}, {31'b0, v.exp_burst});
      chk($sformatf("v%0d_m_wen", idx), {31'b0, m_wen}, {31'b0, v.exp_wen});
      chk($sformatf("v%0d_m_wdata", idx), m_wdata, v.exp_wdata);
      chk($sformatf("v%0d_m_wstrb", idx), 32'(m_wstrb), 32'(v.exp_wstrb));
      for (int k = 0; k <= int'(v.len); k++) begin
         beat(32'(v.rbase * (k + 1)), v.is_d);
         if (k < int'(v.len))
            chk($sformatf("v%0d_hold_b%0d", idx, k), {30'b0, grant}, {30'b0, v.exp_grant});
      end
      i_valid = 1'b0;
      d_valid = 1'b0;
      chk($sformatf("v%0d_end_grant", idx), {30'b0, grant}, 32'd0);
      m_ready = 1'b1;
      m_rdata = 32'hA5A5_A5A5;
      #1;
      chk($sformatf("v%0d_idle_ready", idx), {30'b0, i_ready, d_ready}, 32'd0);
      chk($sformatf("v%0d_idle_rdata", idx), i_rdata | d_rdata, 32'd0);
      m_ready = 1'b0;
      m_rdata = '0;
   endtask

   // Both masters request together; first_d says who must win.
   task automatic tie_pair(input logic first_d, input int idx);
      i_valid = 1'b1; i_addr = 32'h2000; i_len = '0; i_burst = 1'b0;
      d_valid = 1'b1; d_addr = 32'h3000; d_wen = 1'b0;
      step;
      chk($sformatf("tie%0d_first", idx), {30'b0, grant}, first_d ? 32'd2 : 32'd1);
      beat(32'h100 + idx, first_d);
      if (first_d) d_valid = 1'b0;
      else         i_valid = 1'b0;
      chk($sformatf("tie%0d_gap", idx), {30'b0, grant}, 32'd0);
      step;
      chk($sformatf("tie%0d_second", idx), {30'b0, grant}, first_d ? 32'd1 : 32'd2);
      beat(32'h200 + idx, !first_d);
      i_valid = 1'b0;
      d_valid = 1'b0;
      chk($sformatf("tie%0d_done", idx), {30'b0, grant}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, want finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      logic rr_first_d;
`ifdef ARB_RR_EN
      rr_first_d = 1'b0;
`else
      rr_first_d = 1'b1;
`endif
      vecs[0] = '{1'b0, 32'h8000_0010, 8'd1, 1'b1, 1'b0, 32'h0, 4'h0, 32'h11,
                  2'b01, 8'd1, 1'b1, 1'b0, 32'h0, 4'h0};
      vecs[1] = '{1'b1, 32'h0F00_0004, 8'd0, 1'b0, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h0,
                  2'b10, 8'd0, 1'b0, 1'b1, 32'hDEAD_BEEF, 4'hF};
      vecs[2] = '{1'b1, 32'h0000_0100, 8'd0, 1'b0, 1'b0, 32'h1234, 4'h3, 32'h55,
                  2'b10, 8'd0, 1'b0, 1'b0, 32'h1234, 4'h3};
      vecs[3] = '{1'b0, 32'h8000_0100, 8'd0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h77,
                  2'b01, 8'd0, 1'b0, 1'b0, 32'h0, 4'h0};
      vecs[4] = '{1'b0, 32'h8000_0200, 8'd3, 1'b1, 1'b0, 32'h0, 4'h0, 32'h1000_0001,
                  2'b01, 8'd3, 1'b1, 1'b0, 32'h0, 4'h0};

      // Reset state, with a request held during reset.
      do_reset;
      reset = 1'b1;
      i_valid = 1'b1; i_addr = 32'hFFFF_0000; i_len = 8'd5;
      step;
      chk("rst_grant", {30'b0, grant}, 32'd0);
      chk("rst_m_valid", {31'b0, m_valid}, 32'd0);
      chk("rst_m_addr", m_addr, 32'd0);
      chk("rst_m_len", 32'(m_len), 32'd0);
      i_valid = 1'b0;
      reset = 1'b0;
      step;

      for (int v = 0; v < 5; v++) run_vec(vecs[v], v);

      // Simultaneous requests, twice in a row from a fresh reset.
      do_reset;
      tie_pair(rr_first_d, 0);
      tie_pair(rr_first_d, 1);

      // Error on beat 0 of a 4-beat I-cache burst.
      do_reset;
      i_valid = 1'b1; i_addr = 32'h4000; i_len = 8'd3; i_burst = 1'b1;
      step;
      chk("err0_grant", {30'b0, grant}, 32'd1);
      m_err = 1'b1;
      m_rdata = 32'hBAD;
      #1;
      chk("err0_i_err", {31'b0, i_err}, 32'd1);
      chk("err0_no_ready", {30'b0, i_ready, d_ready}, 32'd0);
      chk("err0_d_err", {31'b0, d_err}, 32'd0);
      step;
      m_err = 1'b0;
      chk("err0_idle", {30'b0, grant}, 32'd0);
      step;
      chk("err0_regrant", {30'b0, grant}, 32'd1);
      // Error after one beat: counter must restart on the next grant.
      beat(32'h31, 1'b0);
      m_err = 1'b1;
      #1;
      chk("err1_i_err", {31'b0, i_err}, 32'd1);
      step;
      m_err = 1'b0;
      i_len = 8'd1;
      chk("err1_idle", {30'b0, grant}, 32'd0);
      step;
      chk("err1_regrant_len", 32'(m_len), 32'd1);
      beat(32'h41, 1'b0);
      chk("err1_cnt_restart", {30'b0, grant}, 32'd1);
      beat(32'h42, 1'b0);
      i_valid = 1'b0;
      chk("err1_done", {30'b0, grant}, 32'd0);

      // Reset during beat 2 of a 4-beat burst.
      step;
      i_valid = 1'b1; i_addr = 32'h6000; i_len = 8'd3; i_burst = 1'b1;
      step;
      beat(32'h51, 1'b0);
      beat(32'h52, 1'b0);
      reset = 1'b1;
      step;
      chk("rstmid_m_valid", {31'b0, m_valid}, 32'd0);
      chk("rstmid_grant", {30'b0, grant}, 32'd0);
      reset = 1'b0;
      i_valid = 1'b0;
      d_valid = 1'b1; d_addr = 32'h500; d_wen = 1'b0; d_wstrb = 4'h0;
      step;
      chk("rstmid_d_grant", {30'b0, grant}, 32'd2);
      chk("rstmid_d_addr", m_addr, 32'h500);
      beat(32'h66, 1'b1);
      d_valid = 1'b0;
      chk("rstmid_d_done", {30'b0, grant}, 32'd0);

      chk("sb_empty", sbq.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/ysyx_25040111_bus_arbiter.md
Name: ysyx_25040111_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the single memory read/write port.
- Shares the port between the I-cache refill path (read-only, multi-beat) and the LSU (single-beat read or write).
- Sits between the cache/LSU and the bus bridge.
- Locks a grant for a whole transaction, counts beats itself, and steers ready, data and error back to the granted master only.

Parameters:
- LEN_W, 8, width of the beat-count/length field (length = beats-1).
- D_FIRST, 1, fixed priority on simultaneous requests: 1 = LSU wins, 0 = I-cache wins. Ignored when ARB_RR_EN is defined.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous reset, active-high
- i_valid  in  1  I-cache request; held until its last beat is acknowledged
- i_addr  in  32  I-cache address, passed through combinationally while granted
- i_len  in  LEN_W  I-cache beats-1
- i_burst  in  1  I-cache burst flag
- i_ready  out  1  one-cycle pulse per completed I-cache beat
- i_rdata  out  32  read data to I-cache
- i_err  out  1  error pulse to I-cache
- d_valid  in  1  LSU request
- d_addr  in  32  LSU address
- d_wen  in  1  LSU write enable
- d_wdata  in  32  LSU write data
- d_wstrb  in  4  LSU byte strobes
- d_ready  out  1  LSU completion pulse
- d_rdata  out  32  read data to LSU
- d_err  out  1  error pulse to LSU
- m_valid  out  1  downstream request
- m_addr  out  32  downstream address
- m_len  out  LEN_W  downstream beats-1
- m_burst  out  1  downstream burst flag
- m_wen  out  1  downstream write enable
- m_wdata  out  32  downstream write data
- m_wstrb  out  4  downstream byte strobes
- m_ready  in  1  one pulse per completed downstream beat
- m_rdata  in  32  downstream read data
- m_err  in  1  downstream error
- grant  out  2  current owner: 00 idle, 01 I-cache, 10 LSU

Behaviour:
- Reset: state IDLE, beat counter 0, latched length 0.
  - All outputs 0 at reset: m_valid, m_addr, m_len, m_burst, m_wen, m_wdata, m_wstrb, i_ready, d_ready, i_err, d_err, grant.
  - i_rdata and d_rdata are 0 whenever their master is not granted.
- States: IDLE, GNT_I, GNT_D.
  - State register is clocked; all m_* outputs are combinational muxes of the granted master's signals, forced to 0 in IDLE.
- IDLE transitions:
  - i_valid only -> GNT_I.
  - d_valid only -> GNT_D.
  - Both -> chosen by D_FIRST (or by round-robin under ARB_RR_EN).
  - Latency: request seen at cycle t; grant and m_valid at t+1.
- GNT_I entry:
  - Latch i_len into len_q; counter = 0.
  - m_len = len_q; m_burst = i_burst; m_wen = 0; m_wstrb = 0; m_addr = i_addr live (a non-burst master may advance its address per beat).
- GNT_D entry:
  - len_q = 0; m_len = 0; m_burst = 0; m_wen/m_wdata/m_wstrb = LSU values.
- Beats:
  - m_valid = granted master's valid.
  - Each m_ready while granted: pulse the granted master's ready the same cycle (combinational) and increment the counter.
  - The non-granted master's ready is always 0.
- End of transaction: m_ready && counter == len_q.
  - Return to IDLE next cycle; counter cleared.
  - IDLE lasts at least one cycle, so a master dropping valid on the cycle after its last ready is never re-granted.
  - Counter width LEN_W+1; no wrap occurs because len_q ≤ 2^LEN_W-1.
- m_err while granted:
  - Pulse the granted master's err that cycle (its ready is not asserted).
  - Abort to IDLE; counter cleared.
  - m_err in IDLE is ignored.
- m_ready in IDLE: ignored; no ready pulses.
- Granted master drops valid mid-transaction: grant is still held until the last beat or an error (the slave owns completion).
- Reset mid-transaction: immediate return to IDLE next cycle, all outputs 0; outstanding beats are discarded.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: round-robin on simultaneous requests.
  - A last_owner flop (reset = LSU) records the last completed or aborted owner; the other master wins a tie.
  - A lone requester is always granted.
- Undefined: fixed priority per D_FIRST; no last_owner flop.

Test Plan:
- I-cache burst alone: i_valid=1, i_addr=0x8000_0010, i_len=1, i_burst=1; m_ready pulses twice with m_rdata 0x11, 0x22 -> grant=01 at t+1; m_len=1; i_ready pulses twice with i_rdata 0x11, 0x22; IDLE after 2nd beat; d_ready stays 0.
- LSU write: d_valid=1, d_wen=1, d_addr=0x0F00_0004, d_wdata=0xDEADBEEF, d_wstrb=0xF -> m_wen=1, m_len=0, m_wdata=0xDEADBEEF; d_ready on the first m_ready; grant returns 00.
- Simultaneous requests, D_FIRST=1, no ARB_RR_EN -> LSU served first, then I-cache after one IDLE cycle; repeated ties always serve LSU first.
- Same tie with ARB_RR_EN, last_owner=LSU after reset -> I-cache first, then LSU; next tie serves I-cache.
- m_err on beat 0 of an I-cache len=3 burst -> i_err pulse, no i_ready, grant=00 next cycle, counter=0.
- reset asserted during beat 2 of a len=3 burst -> m_valid=0 and grant=00 the next cycle; a new d_valid is granted normally afterward.
